// File: rtl/uart_wb_master_if.sv
// Wishbone classic bus bundle for the UART command engine.
// The master modport belongs to uart_wb_master; the slave modport is the system bus side.
interface uart_wb_master_if;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_ack_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    output wb_dat_i, wb_ack_i
  );
endinterface

// File: rtl/uart_wb_master.sv
// UART byte-stream to Wishbone initiator: decodes 'W'/'R' command frames,
// runs one 32-bit classic bus cycle per frame and answers through UART TX.
// Optional bus timeout (response 0x15) is built when UART_WB_TIMEOUT_EN is defined.
module uart_wb_master
`ifdef UART_WB_TIMEOUT_EN
  #(parameter int unsigned WB_TIMEOUT = 1023)
`endif
  (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       rx_data,
  input  logic             rx_avail,
  input  logic             rx_error,
  output logic             rx_ack,
  output logic [7:0]       tx_data,
  output logic             tx_wr,
  input  logic             tx_busy,
  uart_wb_master_if.master wb,
  output logic             busy
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_BUS, S_RESP} state_t;

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_OK  = 8'h06;
  localparam logic [7:0] RSP_TMO = 8'h15;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        rx_ack_q, rx_ack_d;
  logic        tx_wr_q, tx_wr_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [31:0] rdata_q, rdata_d;
  logic        we_q, we_d;
  logic        cyc_q, cyc_d;
  logic        fail_q, fail_d;
`ifdef UART_WB_TIMEOUT_EN
  logic [15:0] tmo_q, tmo_d;
`endif

  logic        rx_take;
  logic        rx_err;
  logic [2:0]  resp_len;
  logic [7:0]  resp_byte;

  // Next-state, frame assembly, bus control and response sequencing.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rx_ack_d  = 1'b0;
    tx_wr_d   = 1'b0;
    tx_data_d = tx_data_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    rdata_d   = rdata_q;
    we_d      = we_q;
    cyc_d     = cyc_q;
    fail_d    = fail_q;
`ifdef UART_WB_TIMEOUT_EN
    tmo_d     = tmo_q;
`endif

    rx_take  = rx_avail && !rx_ack_q;
    rx_err   = rx_error && !rx_avail && !rx_ack_q;
    resp_len = (fail_q || we_q) ? 3'd1 : 3'd5;
    case (cnt_q)
      3'd0:    resp_byte = fail_q ? RSP_TMO : RSP_OK;
      3'd1:    resp_byte = rdata_q[31:24];
      3'd2:    resp_byte = rdata_q[23:16];
      3'd3:    resp_byte = rdata_q[15:8];
      default: resp_byte = rdata_q[7:0];
    endcase

    unique case (state_q)
      S_IDLE: begin
        if (rx_take) begin
          rx_ack_d = 1'b1;
          if (rx_data == CMD_WR || rx_data == CMD_RD) begin
            we_d    = (rx_data == CMD_WR);
            state_d = S_ADDR;
            cnt_d   = '0;
          end
        end else if (rx_err) begin
          rx_ack_d = 1'b1;
        end
      end
      S_ADDR, S_DATA: begin
        if (rx_take) begin
          rx_ack_d = 1'b1;
          cnt_d    = cnt_q + 3'd1;
          if (state_q == S_ADDR) adr_d = {adr_q[23:0], rx_data};
          else                   dat_d = {dat_q[23:0], rx_data};
          if (cnt_q == 3'd3) begin
            cnt_d = '0;
            if (state_q == S_ADDR && we_q) begin
              state_d = S_DATA;
            end else begin
              state_d = S_BUS;
              cyc_d   = 1'b1;
`ifdef UART_WB_TIMEOUT_EN
              tmo_d   = 16'(WB_TIMEOUT);
`endif
            end
          end
        end else if (rx_err) begin
          rx_ack_d = 1'b1;
          state_d  = S_IDLE;
          cnt_d    = '0;
        end
      end
      S_BUS: begin
        // The first response byte is launched on the same edge that ends the
        // bus cycle, so RESP counts bytes by observing its own tx_wr pulses.
        if (wb.wb_ack_i) begin
          rdata_d = wb.wb_dat_i;
          fail_d  = 1'b0;
          cyc_d   = 1'b0;
          state_d = S_RESP;
          cnt_d   = '0;
          if (!tx_busy) begin
            tx_wr_d   = 1'b1;
            tx_data_d = RSP_OK;
          end
        end
`ifdef UART_WB_TIMEOUT_EN
        else if (tmo_q == '0) begin
          fail_d  = 1'b1;
          cyc_d   = 1'b0;
          state_d = S_RESP;
          cnt_d   = '0;
          if (!tx_busy) begin
            tx_wr_d   = 1'b1;
            tx_data_d = RSP_TMO;
          end
        end else begin
          tmo_d = tmo_q - 16'd1;
        end
`endif
      end
      S_RESP: begin
        if (tx_wr_q) begin
          cnt_d = cnt_q + 3'd1;
        end else if (cnt_q == resp_len) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (!tx_busy) begin
          tx_wr_d   = 1'b1;
          tx_data_d = resp_byte;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        cyc_d   = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rx_ack_q  <= 1'b0;
      tx_wr_q   <= 1'b0;
      tx_data_q <= '0;
      adr_q     <= '0;
      dat_q     <= '0;
      rdata_q   <= '0;
      we_q      <= 1'b0;
      cyc_q     <= 1'b0;
      fail_q    <= 1'b0;
`ifdef UART_WB_TIMEOUT_EN
      tmo_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rx_ack_q  <= rx_ack_d;
      tx_wr_q   <= tx_wr_d;
      tx_data_q <= tx_data_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      rdata_q   <= rdata_d;
      we_q      <= we_d;
      cyc_q     <= cyc_d;
      fail_q    <= fail_d;
`ifdef UART_WB_TIMEOUT_EN
      tmo_q     <= tmo_d;
`endif
    end
  end

  assign rx_ack      = rx_ack_q;
  assign tx_wr       = tx_wr_q;
  assign tx_data     = tx_data_q;
  assign wb.wb_adr_o = adr_q;
  assign wb.wb_dat_o = dat_q;
  assign wb.wb_we_o  = we_q;
  assign wb.wb_cyc_o = cyc_q;
  assign wb.wb_stb_o = cyc_q;
  assign wb.wb_sel_o = '1;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: doc/uart_wb_master.md
# uart_wb_master

Host-side command engine that sits on the byte interface of the on-chip UART and acts as a Wishbone initiator. It consumes received bytes, decodes simple read/write command frames, runs one 32-bit Wishbone classic cycle per frame, and returns status and data bytes through the UART transmitter. It is intended as a debug and boot path into the LM32 system bus, without CPU involvement.

## Interface
- WB_TIMEOUT, 1023: Wishbone cycles to wait for `wb_ack_i` before aborting. Used only with `UART_WB_TIMEOUT_EN`. Range 1..65535.
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- rx_data  in  8  received byte from UART
- rx_avail  in  1  received byte valid (level, held until acked)
- rx_error  in  1  framing error (level, held until acked)
- rx_ack  out  1  one-cycle pulse; clears rx_avail/rx_error in UART
- tx_data  out  8  byte to transmit
- tx_wr  out  1  one-cycle write strobe to UART TX
- tx_busy  in  1  UART TX busy
- wb_adr_o  out  32  byte address
- wb_dat_o  out  32  write data
- wb_dat_i  in  32  read data
- wb_sel_o  out  4  constant 4'hF
- wb_we_o  out  1  1 = write
- wb_cyc_o  out  1  bus cycle
- wb_stb_o  out  1  strobe, identical to wb_cyc_o
- wb_ack_i  in  1  slave acknowledge
- busy  out  1  high in every state except IDLE

## Operation
- Frames use byte order MSB first:
  - Write: 0x57 ('W'), A3 A2 A1 A0, D3 D2 D1 D0.
  - Read: 0x52 ('R'), A3 A2 A1 A0.
- Responses:
  - Write OK: 0x06.
  - Read OK: 0x06, then D3 D2 D1 D0 from the wb_dat_i value captured at ack.
  - Timeout: 0x15 only.
- Any other byte in IDLE is consumed and ignored. No response is sent.
- States:
  - IDLE: a command byte moves to ADDR and latches we.
  - ADDR: 4 bytes shifted into wb_adr_o. Then DATA if write, else BUS.
  - DATA: 4 bytes shifted into wb_dat_o. Then BUS.
  - BUS: cyc/stb asserted. Leaves on ack or timeout.
  - RESP: emits 1 or 5 bytes. Then IDLE.
- Byte consume rule: a byte is consumed when `rx_avail && !rx_ack`. rx_data is captured in that cycle. rx_ack is registered high for exactly the next cycle.
- Framing errors: if `rx_error && !rx_avail && !rx_ack` occurs in IDLE, ADDR or DATA, pulse rx_ack, discard the partial frame and go to IDLE. No response is sent.
- In BUS and RESP, rx bytes are not consumed. They stay pending in the UART.
- Transmit rule: tx_wr is pulsed when `!tx_busy && !tx_wr`. The next byte waits for tx_busy to go low again.
- Byte counter: 3 bits, cleared on every state entry.
- Reset values: rx_ack 0, tx_wr 0, tx_data 0, wb_adr_o 0, wb_dat_o 0, wb_we_o 0, wb_cyc_o 0, wb_stb_o 0, busy 0, state IDLE.
- Reset mid-operation: cyc/stb drop on the cycle after reset is sampled. The frame is lost and nothing is transmitted.

## Timing
- Frame byte consumed at edge N: cyc/stb high from N+1.
- wb_ack_i sampled high at edge M: data captured at M, cyc/stb low from M+1, first tx_wr at M+1 if tx_busy is low.
- Single-cycle bus: cyc/stb are high for one cycle when ack returns in the same cycle.
- wb_ack_i outside BUS is ignored.
- wb_we_o, wb_adr_o and wb_dat_o are stable for the whole cycle.

## Configuration
- `UART_WB_TIMEOUT_EN` defined: a 16-bit counter loads WB_TIMEOUT on BUS entry and decrements each cycle without ack. When it reaches 0 with no ack, cyc/stb drop on the next cycle and the response is 0x15. Ack in the same cycle as zero counts as success.
- Not defined: BUS waits indefinitely for ack. The counter is not instantiated and 0x15 is never generated.

## Test plan
- Write: bytes 57 00 00 10 00 DE AD BE EF -> one cycle with we=1, adr=0x00001000, dat=0xDEADBEEF, sel=F. After ack, a single tx byte 0x06.
- Read: 52 00 00 20 04, slave acks after 3 cycles with 0x12345678 -> tx 06 12 34 56 78 in order. Each tx_wr is issued only while tx_busy=0.
- Garbage: 00 FF 41, then a valid read -> first three bytes acked, no bus cycle and no tx. The read completes normally.
- rx_error after 57 00 00 -> rx_ack pulse and return to IDLE. A following valid write executes with the correct address.
- Timeout (macro on, WB_TIMEOUT=8), slave never acks -> cyc high for 9 cycles, then tx 0x15 and busy low. With the macro off, cyc stays high.
- Reset asserted during BUS -> cyc/stb/busy low the next cycle. No tx_wr, and a subsequent frame works.
